// File: rtl/switcher_loader_if.sv
// rtl/switcher_loader_if.sv - route-select word handshake between word source and loader
interface switcher_loader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/switcher_loader.sv
// rtl/switcher_loader.sv - serial frame loader and slot-counter mirror for the 8-lane switch stage
module switcher_loader #(
  parameter int WIDTH      = 8,
  parameter int SLOT_BITS  = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  switcher_loader_if.slave     wif,
  input  logic                 resync,
  output logic                 sw_rst,
  output logic                 sda,
  output logic [SLOT_BITS-1:0] slot,
  output logic [WIDTH-1:0]     word_q,
  output logic                 applied
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0]        RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [SLOT_BITS-1:0] LAST_BIT   = SLOT_BITS'(WIDTH);
  localparam logic [SLOT_BITS-1:0] APPLY_SLOT = SLOT_BITS'(WIDTH + 1);

  typedef enum logic [0:0] {ST_RST, ST_RUN} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        rst_cnt, rst_cnt_n;
  logic [SLOT_BITS-1:0] slot_n;
  logic [SLOT_BITS-1:0] bit_idx;
  logic [WIDTH-1:0]     word_q_n;
  logic [WIDTH-1:0]     shifted;
  logic [WIDTH-1:0]     shadow, shadow_n;
  logic                 shadow_full, shadow_full_n;
  logic                 pending, pending_n;
  logic                 sw_rst_n, sda_n, applied_n;
  logic                 accept, commit;

  // The shadow register decouples the word source from frame timing.
  assign wif.word_ready = ~shadow_full;

  // State and output registers; async reset forces the switch stage into reset at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RST;
      rst_cnt     <= '0;
      sw_rst      <= 1'b1;
      sda         <= 1'b0;
      slot        <= '0;
      word_q      <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      pending     <= 1'b0;
      applied     <= 1'b0;
    end else begin
      state       <= state_n;
      rst_cnt     <= rst_cnt_n;
      sw_rst      <= sw_rst_n;
      sda         <= sda_n;
      slot        <= slot_n;
      word_q      <= word_q_n;
      shadow      <= shadow_n;
      shadow_full <= shadow_full_n;
      pending     <= pending_n;
      applied     <= applied_n;
    end
  end

  // Next-state logic: outputs are computed for the cycle after the edge so they stay registered.
  always_comb begin
    state_n       = state;
    rst_cnt_n     = rst_cnt;
    slot_n        = slot;
    word_q_n      = word_q;
    shadow_n      = shadow;
    shadow_full_n = shadow_full;
    pending_n     = pending;
    sw_rst_n      = sw_rst;
    sda_n         = 1'b0;
    applied_n     = 1'b0;
    bit_idx       = '0;
    shifted       = '0;
    commit        = 1'b0;
    accept        = wif.word_valid && !shadow_full;

    if (resync) begin
      // Words and the pending flag survive; only the frame restarts.
      state_n   = ST_RST;
      rst_cnt_n = '0;
      slot_n    = '0;
      sw_rst_n  = 1'b1;
    end else begin
      case (state)
        ST_RST: begin
          sw_rst_n = 1'b1;
          slot_n   = '0;
          if (rst_cnt == RST_LAST) begin
            state_n   = ST_RUN;
            rst_cnt_n = '0;
            sw_rst_n  = 1'b0;
          end else begin
            rst_cnt_n = rst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          sw_rst_n = 1'b0;
          slot_n   = slot + 1'b1;
          // Only swap words between frames so the switch stage never sees a mix.
          if (slot == '0 && shadow_full) begin
            commit    = 1'b1;
            word_q_n  = shadow;
            pending_n = 1'b1;
          end
          if (slot_n != '0 && slot_n <= LAST_BIT) begin
            bit_idx = slot_n - 1'b1;
            shifted = word_q_n >> bit_idx;
            sda_n   = shifted[0];
          end
          if (pending && slot_n == APPLY_SLOT) begin
            applied_n = 1'b1;
            pending_n = 1'b0;
          end
        end
        default: begin
          state_n  = ST_RST;
          sw_rst_n = 1'b1;
        end
      endcase
    end

    if (commit) shadow_full_n = 1'b0;
    if (accept) begin
      shadow_n      = wif.word_in;
      shadow_full_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_switcher_loader.sv
// tb/tb_switcher_loader.sv - scoreboard bench for switcher_loader
module tb_switcher_loader;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       resync = 1'b0;
  logic       sw_rst, sda, applied;
  logic [3:0] slot;
  logic [7:0] word_q;

  typedef struct packed {
    logic [7:0] word;
    logic       appl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  switcher_loader_if #(.WIDTH(W)) wif();

  switcher_loader #(.WIDTH(W), .SLOT_BITS(4), .RST_CYCLES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .wif     (wif),
    .resync  (resync),
    .sw_rst  (sw_rst),
    .sda     (sda),
    .slot    (slot),
    .word_q  (word_q),
    .applied (applied)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_slot(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(reset && !sw_rst && slot == k) && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_slot_%0d: timeout, slot %0d sw_rst %0b", k, slot, sw_rst);
    end
  endtask

  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    wif.word_valid = 1'b1;
    wif.word_in    = w;
    while (!wif.word_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("ready_drop_after_accept", wif.word_ready, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout_left", exp_q.size(), 0);
  endtask

  // Monitor: assemble sda over slots 1..W, compare whole frames at slot W+1.
  initial begin
    int   cnt;
    logic [7:0] cap;
    exp_t e;
    cnt = 0;
    cap = '0;
    forever begin
      @(negedge clk);
      if (!reset || sw_rst) begin
        cnt = 0;
        check("sda_zero_in_reset", sda, 1'b0);
        check("applied_zero_in_reset", applied, 1'b0);
      end else begin
        if (slot >= 1 && slot <= W) begin
          cap[slot-1] = sda;
          cnt++;
        end
        if (slot == W + 1 && cnt == W) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_word", cap, e.word);
            check("frame_applied", applied, e.appl);
          end else begin
            check("unexpected_applied", applied, 1'b0);
          end
          cnt = 0;
        end else begin
          check("applied_off_slot", applied, 1'b0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wif.word_valid = 1'b0;
    wif.word_in    = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_sw_rst", sw_rst, 1'b1);
    check("rst_sda", sda, 1'b0);
    check("rst_slot", slot, 0);
    check("rst_word_q", word_q, 0);
    check("rst_ready", wif.word_ready, 1'b1);
    check("rst_applied", applied, 1'b0);

    // 1: reset release, idle frame of zeros
    exp_q.push_back({8'h00, 1'b0});
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); check("t1_rst_cyc0", sw_rst, 1'b1);
    @(negedge clk); check("t1_rst_cyc1", sw_rst, 1'b1);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      check("t1_sw_rst_run", sw_rst, 1'b0);
      check("t1_slot_seq", slot, k % 16);
    end

    // 2: A5 accepted during RST
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back({8'hA5, 1'b1});
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    send(8'hA5);
    wif.word_valid = 1'b0;
    wait_slot(1);
    check("t2_ready_back", wif.word_ready, 1'b1);
    check("t2_sda_slot1", sda, 1'b1);
    wait_slot(9);

    // 3: 3C offered mid-frame lands whole in the next frame
    exp_q.push_back({8'hA5, 1'b0});
    exp_q.push_back({8'h3C, 1'b1});
    exp_q.push_back({8'h3C, 1'b0});
    wait_slot(4);
    send(8'h3C);
    wif.word_valid = 1'b0;
    wait_slot(0);
    check("t3_word_q_hold", word_q, 8'hA5);
    wait_slot(1);
    check("t3_word_q_new", word_q, 8'h3C);
    check("t3_sda_slot1", sda, 1'b0);
    wait_drain();

    // 4: back-to-back words
    exp_q.push_back({8'h11, 1'b1});
    exp_q.push_back({8'h22, 1'b1});
    exp_q.push_back({8'h33, 1'b1});
    exp_q.push_back({8'h33, 1'b0});
    send(8'h11);
    send(8'h22);
    send(8'h33);
    wif.word_valid = 1'b0;
    wait_drain();

    // 5: resync during a pending frame
    exp_q.push_back({8'h5A, 1'b1});
    exp_q.push_back({8'h5A, 1'b0});
    send(8'h5A);
    wif.word_valid = 1'b0;
    wait_slot(1);
    wait_slot(5);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    check("t5_rst_cyc0", sw_rst, 1'b1);
    check("t5_slot_cleared", slot, 0);
    @(negedge clk); check("t5_rst_cyc1", sw_rst, 1'b1);
    @(negedge clk);
    check("t5_run_again", sw_rst, 1'b0);
    check("t5_run_slot0", slot, 0);
    check("t5_word_kept", word_q, 8'h5A);
    wait_drain();

    // 6: async reset mid-frame
    wait_slot(6);
    #1 reset = 1'b0;
    #1;
    check("t6_async_sw_rst", sw_rst, 1'b1);
    check("t6_async_sda", sda, 1'b0);
    check("t6_async_slot", slot, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t6_word_q_cleared", word_q, 0);
    check("t6_ready", wif.word_ready, 1'b1);
    exp_q.push_back({8'h00, 1'b0});
    wait_drain();

    check("queue_empty_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
